jtcop_obj_dma: RTL

Sequencer for the object-table copy path. It arms on a CPU copy request, waits for the next vertical blank, then walks the CPU-side object buffer one word per pixel-clock enable. Each word is written into the engine-side shadow table. It sits between the CPU object RAM, the shadow table RAM and the object engine, and reports busy, completion and overrun status.

---
 rtl/jtcop_obj_dma.sv | 118 +++++++++++
 1 files changed

// File: rtl/jtcop_obj_dma.sv
// Object-table copy sequencer: on a CPU request, waits for the next vblank and then
// streams the CPU object buffer into the engine shadow table, one word per pixel enable.
module jtcop_obj_dma #(
  parameter int AW    = 10,
  parameter int WORDS = 1024,
  parameter int RDLAT = 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LVBL,
  input  logic          obj_copy,
  output logic [AW-1:0] src_addr,
  input  logic [15:0]   src_dout,
  output logic [AW-1:0] dst_addr,
  output logic [15:0]   dst_din,
  output logic [1:0]    dst_we,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

  localparam logic [AW:0] LAST = (AW+1)'(WORDS-1);

  state_t        st;
  logic [AW:0]   cnt;
  logic [1:0]    dcnt;
  logic          pending, lvbl_l, iss, aborted;
  logic          fall;

  logic [RDLAT-1:0] vld_sr;
  logic [AW-1:0]    adr_sr [RDLAT];

  assign fall = pxl_cen & lvbl_l & ~LVBL;

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= '0;
      dcnt     <= '0;
      pending  <= 1'b0;
      lvbl_l   <= 1'b0;
      iss      <= 1'b0;
      aborted  <= 1'b0;
      src_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      iss  <= 1'b0;
      if (pxl_cen) lvbl_l <= LVBL;
      if (obj_copy) pending <= 1'b1;
      case (st)
        IDLE: if (pending) st <= ARMED;
        ARMED: if (fall) begin
          cnt     <= '0;
          pending <= obj_copy;  // a request landing on the start cycle queues another copy
          aborted <= 1'b0;
          busy    <= 1'b1;
          st      <= RUN;
        end
        RUN: if (pxl_cen) begin
          if (LVBL) begin
            // blank ended before the table was complete: retry from word 0 next frame
            overrun <= 1'b1;
            pending <= 1'b1;
            aborted <= 1'b1;
            dcnt    <= '0;
            st      <= DRAIN;
          end else begin
            src_addr <= cnt[AW-1:0];
            iss      <= 1'b1;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST) begin
              dcnt <= '0;
              st   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'(RDLAT) && !aborted) begin
            done    <= 1'b1;
            overrun <= 1'b0;
          end
          if (dcnt == 2'(RDLAT+1)) begin
            busy <= 1'b0;
            st   <= pending ? ARMED : IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // issue flag and address travel beside the RAM read so the write lines up with src_dout
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      for (int i = 0; i < RDLAT; i++) adr_sr[i] <= '0;
    end else begin
      vld_sr[0] <= iss;
      adr_sr[0] <= src_addr;
      for (int i = 1; i < RDLAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        adr_sr[i] <= adr_sr[i-1];
      end
    end
  end

  assign dst_we   = {2{vld_sr[RDLAT-1]}};
  assign dst_addr = adr_sr[RDLAT-1];
  assign dst_din  = vld_sr[RDLAT-1] ? src_dout : 16'd0;

endmodule
